// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states, abs helper.
package muldiv_pkg;

  // abs_w works on this fixed width; callers zero-extend and truncate, so WIDTH must be <= 64.
  localparam int unsigned ABS_MAX_W = 64;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic [ABS_MAX_W-1:0] abs_w(input logic [ABS_MAX_W-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder and
// subtract the divisor when it fits, shifting the resulting quotient bit in from the right.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic           fits;

  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, divisor_i});
  // rem_i < divisor, so after a successful subtract the remainder always fits in WIDTH bits.
  assign rem_o   = fits ? WIDTH'(shifted - {1'b0, divisor_i}) : shifted[WIDTH-1:0];
  assign quo_o   = {quo_i[WIDTH-2:0], fits};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers; busy stalls the pipeline while
// an operation runs, done pulses for one cycle when hi/lo carry the new result.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               dz_pend_q;
  logic               busy_q;
  logic               done_q;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               is_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  assign is_signed = ~op[0];
  assign abs_a     = WIDTH'(abs_w(ABS_MAX_W'(a), is_signed & a[WIDTH-1]));
  assign abs_b     = WIDTH'(abs_w(ABS_MAX_W'(b), is_signed & b[WIDTH-1]));

  // Multiply: acc holds {partial product, remaining multiplier bits}; add then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_d;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_d   = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc holds {partial remainder, dividend/quotient}.
  logic [WIDTH-1:0] div_rem_d;
  logic [WIDTH-1:0] div_quo_d;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
    .quo_i     (acc_q[WIDTH-1:0]),
    .divisor_i (opnd_q),
    .rem_o     (div_rem_d),
    .quo_o     (div_quo_d)
  );

  logic [2*WIDTH-1:0] acc_d;
  assign acc_d = is_div_q ? {div_rem_d, div_quo_d} : mul_d;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;
  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign hi_d     = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_d     = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_pend_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hi_wr) hi_q <= wdata;
          if (lo_wr) lo_q <= wdata;
          if (start && !flush) begin
            is_div_q <= op[1];
            cnt_q    <= CNT_W'(WIDTH);
            busy_q   <= 1'b1;
            if (op[1] && (b == '0)) begin
              // Divide by zero skips the iterations; FIX passes {a, all-ones} straight through.
              acc_q     <= {a, {WIDTH{1'b1}}};
              opnd_q    <= b;
              neg_res_q <= 1'b0;
              neg_rem_q <= 1'b0;
              dz_pend_q <= 1'b1;
              state_q   <= S_FIX;
            end else begin
              acc_q     <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
              opnd_q    <= op[1] ? abs_b : abs_a;
              neg_res_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem_q <= is_signed & op[1] & a[WIDTH-1];
              dz_pend_q <= 1'b0;
              state_q   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (!flush) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= 1'b1;
            dz_q   <= dz_pend_q;
          end
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
